// File: rtl/alu_pkg.sv
// Shared ALU constants: datapath width and the carry-select split point.
package alu_pkg;
  localparam int unsigned ALU_WIDTH = 32;
  localparam int unsigned CSA_SPLIT = 16;
endpackage

// File: rtl/rca_16b.sv
// 16-bit ripple-carry adder built from a chain of 1-bit full adders.
// c15 is the carry into the MSB, used upstream for signed overflow.
module rca_16b
  import alu_pkg::*;
(
  input  logic [CSA_SPLIT-1:0] x,
  input  logic [CSA_SPLIT-1:0] y,
  input  logic                 ci,
  output logic [CSA_SPLIT-1:0] s,
  output logic                 co,
  output logic                 c15
);

  logic [CSA_SPLIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CSA_SPLIT; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
  end

  assign co  = c[CSA_SPLIT];
  assign c15 = c[CSA_SPLIT-1];

endmodule

// File: rtl/csa_32b_by_rca.sv
// 32-bit carry-select adder: ripple low half, speculative high halves for
// carry-in 0 and 1, selected by the low-half carry; outputs registered.
module csa_32b_by_rca
  import alu_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ALU_WIDTH-1:0] a,
  input  logic [ALU_WIDTH-1:0] b,
  input  logic                 c_in,
  output logic [ALU_WIDTH-1:0] sum,
  output logic                 c_out,
  output logic                 ovf
);

  logic [CSA_SPLIT-1:0]           lo_s;
  logic                           c16;
  logic                           lo_c15_unused;
  logic [ALU_WIDTH-CSA_SPLIT-1:0] hi_s0, hi_s1, hi_s;
  logic                           hi_co0, hi_co1, hi_c15_0, hi_c15_1;
  logic                           co_sel, c31_in;
  logic [ALU_WIDTH-1:0]           sum_d;

  rca_16b u_lo (
    .x  (a[CSA_SPLIT-1:0]),
    .y  (b[CSA_SPLIT-1:0]),
    .ci (c_in),
    .s  (lo_s),
    .co (c16),
    .c15(lo_c15_unused)
  );

  rca_16b u_hi0 (
    .x  (a[ALU_WIDTH-1:CSA_SPLIT]),
    .y  (b[ALU_WIDTH-1:CSA_SPLIT]),
    .ci (1'b0),
    .s  (hi_s0),
    .co (hi_co0),
    .c15(hi_c15_0)
  );

  rca_16b u_hi1 (
    .x  (a[ALU_WIDTH-1:CSA_SPLIT]),
    .y  (b[ALU_WIDTH-1:CSA_SPLIT]),
    .ci (1'b1),
    .s  (hi_s1),
    .co (hi_co1),
    .c15(hi_c15_1)
  );

  assign hi_s   = c16 ? hi_s1    : hi_s0;
  assign co_sel = c16 ? hi_co1   : hi_co0;
  assign c31_in = c16 ? hi_c15_1 : hi_c15_0;
  assign sum_d  = {hi_s, lo_s};

  always_ff @(posedge clock) begin
    if (reset) begin
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      sum   <= sum_d;
      c_out <= co_sel;
      ovf   <= c31_in ^ co_sel;
    end
  end

endmodule

// File: tb/tb_csa_32b_by_rca.sv
// Self-checking bench for csa_32b_by_rca: directed plan cases plus random
// operands, compared against a plain-arithmetic reference model.
module tb_csa_32b_by_rca;

  logic        clock;
  logic        reset;
  logic [31:0] a, b;
  logic        c_in;
  logic [31:0] sum;
  logic        c_out, ovf;

  int n_tests = 0;
  int n_fail  = 0;

  csa_32b_by_rca dut (
    .clock(clock),
    .reset(reset),
    .a    (a),
    .b    (b),
    .c_in (c_in),
    .sum  (sum),
    .c_out(c_out),
    .ovf  (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                input logic mc, output logic [31:0] ms,
                                output logic mco, output logic mov);
    logic [32:0] r;
    r   = {1'b0, ma} + {1'b0, mb} + {32'b0, mc};
    ms  = r[31:0];
    mco = r[32];
    mov = (ma[31] == mb[31]) && (ms[31] != ma[31]);
  endfunction

  task automatic check(input string tag, input logic [31:0] es,
                       input logic eco, input logic eov);
    n_tests++;
    assert ({sum, c_out, ovf} === {es, eco, eov})
    else begin
      n_fail++;
      $error("FAIL %s: got sum=%08h c_out=%0b ovf=%0b, want sum=%08h c_out=%0b ovf=%0b",
             tag, sum, c_out, ovf, es, eco, eov);
    end
  endtask

  // Drive operands, clock once, compare against the model one cycle later.
  task automatic add_check(input string tag, input logic [31:0] ta,
                           input logic [31:0] tb_, input logic tc);
    logic [31:0] es;
    logic        eco, eov;
    a = ta; b = tb_; c_in = tc;
    model(ta, tb_, tc, es, eco, eov);
    @(posedge clock); #1;
    check(tag, es, eco, eov);
  endtask

  initial begin
    logic [31:0] ra, rb;
    reset = 1'b1; a = 32'h7fffffff; b = 32'h10000000; c_in = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("reset_init", 32'h0, 1'b0, 1'b0);
    reset = 1'b0;

    add_check("zero",        32'h00000000, 32'h00000000, 1'b0);
    add_check("pass",        32'h00000000, 32'h006f7d00, 1'b0);
    add_check("pass_ones",   32'hffffffff, 32'h00000000, 1'b0);
    check("pass_ones_abs", 32'hffffffff, 1'b0, 1'b0);

    for (int i = 0; i <= 30; i++) begin
      add_check($sformatf("walk_%0d", i), 32'h1 << i, 32'h1 << i, 1'b0);
      n_tests++;
      assert (sum === (32'h1 << (i + 1)))
      else begin
        n_fail++;
        $error("FAIL walk_abs_%0d: got %08h want %08h", i, sum, 32'h1 << (i + 1));
      end
    end
    check("walk30_abs", 32'h80000000, 1'b0, 1'b1);

    add_check("wrap_1",      32'hffffffff, 32'h00000001, 1'b0);
    check("wrap_1_abs", 32'h00000000, 1'b1, 1'b0);
    add_check("wrap_f",      32'hffffffff, 32'hf0000000, 1'b0);
    check("wrap_f_abs", 32'hefffffff, 1'b1, 1'b0);
    add_check("sovf_pos",    32'h7fffffff, 32'h10000000, 1'b0);
    check("sovf_pos_abs", 32'h8fffffff, 1'b0, 1'b1);
    add_check("sovf_neg",    32'h80000000, 32'h80000000, 1'b0);
    check("sovf_neg_abs", 32'h00000000, 1'b1, 1'b1);
    add_check("sel_bound",   32'h0000ffff, 32'h00000001, 1'b0);
    check("sel_bound_abs", 32'h00010000, 1'b0, 1'b0);
    add_check("cin_wrap",    32'hffffffff, 32'h00000000, 1'b1);
    check("cin_wrap_abs", 32'h00000000, 1'b1, 1'b0);
    add_check("cin_sub",     32'h00000005, 32'hfffffffa, 1'b1);
    check("cin_sub_abs", 32'h00000000, 1'b1, 1'b0);

    // Reset mid-stream discards the in-flight result.
    add_check("pre_reset",   32'h7fffffff, 32'h10000000, 1'b0);
    a = 32'h12345678; b = 32'h0000ffff; c_in = 1'b1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("mid_reset", 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    add_check("post_reset",  32'h12345678, 32'h0000ffff, 1'b1);

    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = $urandom;
      case (i % 4)
        1: ra[15:0] = 16'hffff;
        2: rb = ~ra;
        default: ;
      endcase
      add_check($sformatf("rand_%0d", i), ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csa_32b_by_rca.md
# csa_32b_by_rca

32-bit two's-complement adder with carry-in, built as a carry-select adder from ripple-carry sections. It produces the sum, the unsigned carry-out and the signed overflow flag, all registered. It is the arithmetic core used by the ALU's add/subtract path; subtraction is performed upstream by inverting `b` and setting `c_in`.

## Interface
- Parameters: none. Width is fixed at 32 bits and the select split is fixed at 16/16; both come from package constants.
- `clock`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sum`  out  32  registered sum `a + b + c_in`, modulo 2^32.
- `c_out`  out  1  registered carry out of bit 31 (unsigned overflow).
- `ovf`  out  1  registered signed (two's-complement) overflow.
- `a`  in  32  operand A.
- `b`  in  32  operand B.
- `c_in`  in  1  carry into bit 0.

## Operation
- Compute the full 33-bit result `{carry, s} = a + b + c_in`.
- `c_out` is bit 32 of that result.
- `ovf = (a[31] == b[31]) && (s[31] != a[31])`. This is equivalent to carry-into-bit-31 XOR carry-out-of-bit-31.
- Carry-select organisation:
  - Low half `[15:0]`: one 16-bit ripple-carry adder fed by `c_in`, producing `c16`.
  - High half `[31:16]`: two 16-bit ripple-carry adders, one with carry-in 0 and one with carry-in 1, computed in parallel.
  - `c16` selects the high sum, the carry-out and the bit-30 carry used for overflow from the matching copy.
- Each ripple-carry adder is a chain of 1-bit full adders: `s = x ^ y ^ ci`, `co = x&y | x&ci | y&ci`.
- No operand handling beyond the arithmetic. Inputs are never held or latched except by the output registers.

## Timing
- Latency is 1 cycle. Inputs present before rising edge N appear on `sum`, `c_out` and `ovf` after edge N.
- Throughput is one add per cycle. There is no handshake and no valid signal; a new result lands on every edge.
- Reset:
  - On any rising edge with `reset=1`, `sum=32'h0`, `c_out=0`, `ovf=0`.
  - Reset has priority over loading a new result.
  - Reset asserted mid-stream discards the in-flight result.
  - The first edge with `reset=0` loads the result for the inputs present at that edge.
- The combinational path (16-bit ripple plus one mux level) must close in one clock period; there are no internal pipeline stages.
- Boundary behaviour:
  - Wrap-around modulo 2^32 is silent except through `c_out` and `ovf`.
  - `c_out` and `ovf` are independent; both may be 1, for example `80000000+80000000`.

## Structure
- Shared package `alu_pkg` holds `ALU_WIDTH=32` and `CSA_SPLIT=16`.
- One sub-module: `rca_16b` (ports `x[15:0]`, `y[15:0]`, `ci`, `s[15:0]`, `co`, `c15`, where `c15` is the carry into its MSB). It is built from a full-adder bit, either a generate loop or a `full_adder` cell.
- The top level instantiates three `rca_16b`, the select muxes, the overflow logic and the output register.

## Test plan
- Zero and pass-through, `c_in=0`, checked one cycle later:
  - `0+0` -> `sum=00000000`.
  - `00000000+006f7d00` -> `006f7d00`.
  - `ffffffff+00000000` -> `ffffffff`, `c_out=0`, `ovf=0`.
- Walking carry: for i=0..30, `a=b=1<<i` -> `sum=1<<(i+1)`. At i=30, `80000000` with `ovf=1`, `c_out=0`.
- Unsigned wrap:
  - `ffffffff+00000001` -> `00000000`, `c_out=1`, `ovf=0`.
  - `ffffffff+f0000000` -> `efffffff`, `c_out=1`, `ovf=0`.
- Signed overflow:
  - `7fffffff+10000000` -> `8fffffff`, `c_out=0`, `ovf=1`.
  - `80000000+80000000` -> `00000000`, `c_out=1`, `ovf=1`.
- Select boundary and carry-in:
  - `0000ffff+00000001` -> `00010000`.
  - `ffffffff+00000000` with `c_in=1` -> `00000000`, `c_out=1`.
  - `00000005+fffffffa` with `c_in=1` -> `00000000`, `c_out=1`.
- Reset: load `7fffffff+10000000`, then assert `reset` for one edge -> outputs all 0. Deassert -> the next edge shows the result for the current inputs.
